// File: rtl/rds_pkg.sv
// Shared constants for the RDS block decoder: generator polynomial, offset words,
// block identifiers, position/state encodings and the 26-bit syndrome function.
package rds_pkg;

    localparam logic [10:0] GEN_POLY = 11'h5B9;

    localparam logic [9:0] OFS_A  = 10'h0FC;
    localparam logic [9:0] OFS_B  = 10'h198;
    localparam logic [9:0] OFS_C  = 10'h168;
    localparam logic [9:0] OFS_CP = 10'h350;
    localparam logic [9:0] OFS_D  = 10'h1B4;

    localparam logic [2:0] ID_A  = 3'd0;
    localparam logic [2:0] ID_B  = 3'd1;
    localparam logic [2:0] ID_C  = 3'd2;
    localparam logic [2:0] ID_CP = 3'd3;
    localparam logic [2:0] ID_D  = 3'd4;

    // Position inside a group; C and C' share the third slot.
    localparam logic [1:0] POS_A = 2'd0;
    localparam logic [1:0] POS_B = 2'd1;
    localparam logic [1:0] POS_C = 2'd2;
    localparam logic [1:0] POS_D = 2'd3;

    localparam logic [4:0] BLOCK_LAST = 5'd25;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_SYNC    = 2'd2
    } state_e;

    function automatic logic [9:0] poly_mod26(input logic [25:0] win);
        logic [25:0] r;
        r = win;
        for (int i = 25; i >= 10; i--) begin
            if (r[i]) begin
                r = r ^ (26'(GEN_POLY) << (i - 10));
            end
        end
        return r[9:0];
    endfunction

endpackage

// File: rtl/rds_syndrome.sv
// Combinational remainder of a 26-bit RDS window modulo the block generator polynomial.
module rds_syndrome
    import rds_pkg::*;
(
    input  logic [25:0] window,
    output logic [9:0]  syndrome
);

    // Purely combinational polynomial division.
    always_comb begin
        syndrome = poly_mod26(window);
    end

endmodule

// File: rtl/rds_decoder.sv
// RDS block synchroniser and group assembler: finds block boundaries from offset
// syndromes, tracks sync with a bad-block counter and reports blocks and full groups.
module rds_decoder
    import rds_pkg::*;
#(
    parameter int c_loss_limit = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_strobe,
    output logic        synced,
    output logic        block_valid,
    output logic [15:0] block_data,
    output logic [2:0]  block_id,
    output logic        group_valid,
    output logic [63:0] group_data,
    output logic        group_c_prime
);

    localparam logic [8:0] LOSS_LIMIT = 9'(c_loss_limit);

    // The newest bit arrives combinationally, so only 25 history bits need storage.
    logic [24:0] shreg_q, shreg_d;
    state_e      state_q, state_d;
    logic [1:0]  pos_q, pos_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  bad_cnt_q, bad_cnt_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] word_a_q, word_a_d;
    logic [15:0] word_b_q, word_b_d;
    logic [15:0] word_c_q, word_c_d;
    logic        c_prime_q, c_prime_d;
    logic        synced_q, synced_d;
    logic        block_valid_q, block_valid_d;
    logic [15:0] block_data_q, block_data_d;
    logic [2:0]  block_id_q, block_id_d;
    logic        group_valid_q, group_valid_d;
    logic [63:0] group_data_q, group_data_d;
    logic        group_c_prime_q, group_c_prime_d;

    logic [25:0] window_s;
    logic [9:0]  syndrome_s;
    logic        hit_a_s, hit_b_s, hit_c_s, hit_cp_s, hit_d_s, any_hit_s;
    logic        exp_hit_s;
    logic [2:0]  exp_id_s;
    logic [1:0]  search_next_s;
    logic        loss_s;

    assign window_s = {shreg_q, bit_in};

    rds_syndrome u_syndrome (
        .window   (window_s),
        .syndrome (syndrome_s)
    );

    assign hit_a_s   = (syndrome_s == OFS_A);
    assign hit_b_s   = (syndrome_s == OFS_B);
    assign hit_c_s   = (syndrome_s == OFS_C);
    assign hit_cp_s  = (syndrome_s == OFS_CP);
    assign hit_d_s   = (syndrome_s == OFS_D);
    assign any_hit_s = hit_a_s | hit_b_s | hit_c_s | hit_cp_s | hit_d_s;
    assign loss_s    = (({1'b0, bad_cnt_q} + 9'd1) >= LOSS_LIMIT);

    // Match against the offset expected at the current group position.
    always_comb begin
        exp_hit_s = 1'b0;
        exp_id_s  = ID_A;
        case (pos_q)
            POS_A: begin exp_hit_s = hit_a_s;             exp_id_s = ID_A; end
            POS_B: begin exp_hit_s = hit_b_s;             exp_id_s = ID_B; end
            POS_C: begin exp_hit_s = hit_c_s | hit_cp_s;  exp_id_s = hit_cp_s ? ID_CP : ID_C; end
            POS_D: begin exp_hit_s = hit_d_s;             exp_id_s = ID_D; end
            default: begin exp_hit_s = 1'b0;              exp_id_s = ID_A; end
        endcase
    end

    // Position that follows whichever offset was found while searching.
    always_comb begin
        if (hit_a_s) begin
            search_next_s = POS_B;
        end else if (hit_b_s) begin
            search_next_s = POS_C;
        end else if (hit_c_s | hit_cp_s) begin
            search_next_s = POS_D;
        end else begin
            search_next_s = POS_A;
        end
    end

    // Next-state logic for the sync FSM, group collection and outputs.
    always_comb begin
        shreg_d         = shreg_q;
        state_d         = state_q;
        pos_d           = pos_q;
        bit_cnt_d       = bit_cnt_q;
        bad_cnt_d       = bad_cnt_q;
        flags_d         = flags_q;
        word_a_d        = word_a_q;
        word_b_d        = word_b_q;
        word_c_d        = word_c_q;
        c_prime_d       = c_prime_q;
        block_valid_d   = 1'b0;
        block_data_d    = block_data_q;
        block_id_d      = block_id_q;
        group_valid_d   = 1'b0;
        group_data_d    = group_data_q;
        group_c_prime_d = group_c_prime_q;
        if (bit_strobe) begin
            shreg_d = window_s[24:0];
            case (state_q)
                ST_SEARCH: begin
                    if (any_hit_s) begin
                        state_d   = ST_CONFIRM;
                        bit_cnt_d = 5'd0;
                        pos_d     = search_next_s;
                        bad_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_CONFIRM, ST_SYNC: begin
                    if (bit_cnt_q == BLOCK_LAST) begin
                        bit_cnt_d = 5'd0;
                        pos_d     = pos_q + 2'd1;
                        if (exp_hit_s) begin
                            state_d       = ST_SYNC;
                            bad_cnt_d     = 8'd0;
                            block_valid_d = 1'b1;
                            block_data_d  = window_s[25:10];
                            block_id_d    = exp_id_s;
                            if (pos_q == POS_A) begin
                                flags_d = 4'b0001;
                            end else begin
                                flags_d = flags_q | (4'b0001 << pos_q);
                            end
                            case (pos_q)
                                POS_A: word_a_d = window_s[25:10];
                                POS_B: word_b_d = window_s[25:10];
                                POS_C: begin
                                    word_c_d  = window_s[25:10];
                                    c_prime_d = hit_cp_s;
                                end
                                POS_D: begin
                                    if (&flags_q[2:0]) begin
                                        group_valid_d   = 1'b1;
                                        group_data_d    = {word_a_q, word_b_q, word_c_q, window_s[25:10]};
                                        group_c_prime_d = c_prime_q;
                                    end else begin
                                        group_valid_d = 1'b0;
                                    end
                                end
                                default: word_a_d = word_a_q;
                            endcase
                        end else if ((state_q == ST_CONFIRM) || loss_s) begin
                            state_d   = ST_SEARCH;
                            bad_cnt_d = 8'd0;
                            flags_d   = 4'b0000;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 8'd1;
                            if (pos_q == POS_A) begin
                                flags_d = 4'b0000;
                            end else begin
                                flags_d = flags_q;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end else begin
            shreg_d = shreg_q;
        end
        synced_d = (state_d == ST_SYNC);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q         <= 25'd0;
            state_q         <= ST_SEARCH;
            pos_q           <= POS_A;
            bit_cnt_q       <= 5'd0;
            bad_cnt_q       <= 8'd0;
            flags_q         <= 4'd0;
            word_a_q        <= 16'd0;
            word_b_q        <= 16'd0;
            word_c_q        <= 16'd0;
            c_prime_q       <= 1'b0;
            synced_q        <= 1'b0;
            block_valid_q   <= 1'b0;
            block_data_q    <= 16'd0;
            block_id_q      <= 3'd0;
            group_valid_q   <= 1'b0;
            group_data_q    <= 64'd0;
            group_c_prime_q <= 1'b0;
        end else begin
            shreg_q         <= shreg_d;
            state_q         <= state_d;
            pos_q           <= pos_d;
            bit_cnt_q       <= bit_cnt_d;
            bad_cnt_q       <= bad_cnt_d;
            flags_q         <= flags_d;
            word_a_q        <= word_a_d;
            word_b_q        <= word_b_d;
            word_c_q        <= word_c_d;
            c_prime_q       <= c_prime_d;
            synced_q        <= synced_d;
            block_valid_q   <= block_valid_d;
            block_data_q    <= block_data_d;
            block_id_q      <= block_id_d;
            group_valid_q   <= group_valid_d;
            group_data_q    <= group_data_d;
            group_c_prime_q <= group_c_prime_d;
        end
    end

    assign synced        = synced_q;
    assign block_valid   = block_valid_q;
    assign block_data    = block_data_q;
    assign block_id      = block_id_q;
    assign group_valid   = group_valid_q;
    assign group_data    = group_data_q;
    assign group_c_prime = group_c_prime_q;

endmodule

// File: tb/tb_rds_decoder.sv
// Bench for rds_decoder: a directed block table, hand-written loss/reset/order
// sequences and a random group stream, all checked against a bit-level model.
module tb_rds_decoder;

    localparam int LIMIT = 5;
    localparam int O_A = 'h0FC, O_B = 'h198, O_C = 'h168, O_CP = 'h350, O_D = 'h1B4;
    localparam longint unsigned MASK26 = 64'h3FFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_strobe;
    logic        synced;
    logic        block_valid;
    logic [15:0] block_data;
    logic [2:0]  block_id;
    logic        group_valid;
    logic [63:0] group_data;
    logic        group_c_prime;

    rds_decoder #(.c_loss_limit(LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .bit_in        (bit_in),
        .bit_strobe    (bit_strobe),
        .synced        (synced),
        .block_valid   (block_valid),
        .block_data    (block_data),
        .block_id      (block_id),
        .group_valid   (group_valid),
        .group_data    (group_data),
        .group_c_prime (group_c_prime)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: a bit history and the block-level rules
    longint unsigned m_win;
    int  m_mode;   // 0 searching, 1 confirming, 2 locked
    int  m_pos;
    int  m_cnt;
    int  m_badblk;
    bit  m_have[4];
    int  m_word[4];
    bit  m_cp;
    bit  e_sync, e_bv, e_gv, e_cp;
    int  e_data, e_id;
    bit [63:0] e_gdata;

    bit  cap_bv, cap_gv, cap_sync;
    int  bv_seen, gv_seen;

    typedef struct {
        longint unsigned win;
        bit  sync;
        bit  bv;
        int  id;
        int  data;
        bit  gv;
        longint unsigned gdata;
        bit  cp;
    } row_t;
    row_t tbl[16];

    function automatic int gmod(longint unsigned v);
        longint unsigned r = v;
        for (int i = 25; i >= 10; i--) begin
            if (r[i]) r = r ^ (64'h5B9 << (i - 10));
        end
        return int'(r & 64'h3FF);
    endfunction

    function automatic longint unsigned encode(int data, int ofs);
        longint unsigned d = longint'(data & 'hFFFF) << 10;
        return d | longint'(gmod(d) ^ ofs);
    endfunction

    function automatic bit is_offset(int s);
        return (s == O_A) || (s == O_B) || (s == O_C) || (s == O_CP) || (s == O_D);
    endfunction

    function automatic row_t mk(longint unsigned w, bit s, bit v, int id, int d,
                                bit g, longint unsigned gd, bit cp);
        row_t r;
        r = '{w, s, v, id, d, g, gd, cp};
        return r;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win = 0; m_mode = 0; m_pos = 0; m_cnt = 0; m_badblk = 0; m_cp = 1'b0;
        for (int k = 0; k < 4; k++) begin m_have[k] = 1'b0; m_word[k] = 0; end
        e_sync = 0; e_bv = 0; e_gv = 0; e_cp = 0; e_data = 0; e_id = 0; e_gdata = '0;
    endtask

    task automatic model_lose();
        m_mode = 0; m_badblk = 0;
        for (int k = 0; k < 4; k++) m_have[k] = 1'b0;
    endtask

    task automatic model_strobe(input bit b);
        int  syn;
        bit  ok;
        e_bv = 0; e_gv = 0;
        m_win = ((m_win << 1) | 64'(b)) & MASK26;
        syn = gmod(m_win);
        if (m_mode == 0) begin
            if (is_offset(syn)) begin
                m_mode = 1; m_cnt = 0;
                if (syn == O_A)      m_pos = 1;
                else if (syn == O_B) m_pos = 2;
                else if (syn == O_D) m_pos = 0;
                else                 m_pos = 3;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 26) begin
                m_cnt = 0;
                case (m_pos)
                    0: ok = (syn == O_A);
                    1: ok = (syn == O_B);
                    2: ok = (syn == O_C) || (syn == O_CP);
                    default: ok = (syn == O_D);
                endcase
                if (m_pos == 0) for (int k = 0; k < 4; k++) m_have[k] = 1'b0;
                if (ok) begin
                    e_bv   = 1;
                    e_data = int'((m_win >> 10) & 64'hFFFF);
                    e_id   = (m_pos == 0) ? 0 : (m_pos == 1) ? 1 : (m_pos == 3) ? 4 : ((syn == O_CP) ? 3 : 2);
                    m_mode = 2; m_badblk = 0;
                    m_have[m_pos] = 1'b1;
                    m_word[m_pos] = e_data;
                    if (m_pos == 2) m_cp = (syn == O_CP);
                    if (m_pos == 3 && m_have[0] && m_have[1] && m_have[2]) begin
                        e_gv    = 1;
                        e_gdata = {16'(m_word[0]), 16'(m_word[1]), 16'(m_word[2]), 16'(m_word[3])};
                        e_cp    = m_cp;
                    end
                end else if (m_mode == 1) begin
                    model_lose();
                end else begin
                    m_badblk++;
                    if (m_badblk == LIMIT) model_lose();
                end
                m_pos = (m_pos + 1) % 4;
            end
        end
        e_sync = (m_mode == 2);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".synced"},  64'(synced),        64'(e_sync));
        chk({tag, ".bvalid"},  64'(block_valid),   64'(e_bv));
        chk({tag, ".bdata"},   64'(block_data),    64'(e_data));
        chk({tag, ".bid"},     64'(block_id),      64'(e_id));
        chk({tag, ".gvalid"},  64'(group_valid),   64'(e_gv));
        chk({tag, ".gdata"},   group_data,         e_gdata);
        chk({tag, ".gcprime"}, 64'(group_c_prime), 64'(e_cp));
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        bit_in = b; bit_strobe = 1'b1;
        model_strobe(b);
        @(posedge clk); #1;
        cap_bv = block_valid; cap_gv = group_valid; cap_sync = synced;
        if (block_valid) bv_seen++;
        if (group_valid) gv_seen++;
        check_all("strobe");
        @(negedge clk);
        bit_strobe = 1'b0; bit_in = 1'($urandom_range(1));
        e_bv = 0; e_gv = 0;
        @(posedge clk); #1;
        chk("idle.bvalid", 64'(block_valid), 64'(e_bv));
        chk("idle.gvalid", 64'(group_valid), 64'(e_gv));
        repeat ($urandom_range(2)) @(posedge clk);
    endtask

    task automatic send_block(input longint unsigned w);
        for (int i = 25; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bit_strobe = 1'b1; bit_in = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_all("rst_cycle");
        @(negedge clk);
        reset = 1'b0; bit_strobe = 1'b0;
        @(posedge clk); #1;
        check_all("rst_after");
    endtask

    function automatic bit prefix_clean(int r);
        longint unsigned w;
        for (int j = 0; j < 26; j++) begin
            w = ((longint'(r) << j) | (64'h0FC >> (26 - j))) & MASK26;
            if (is_offset(gmod(w))) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        int r7;
        int pos_ofs[4];
        longint unsigned w;
        pos_ofs = '{O_A, O_B, O_C, O_D};
        reset = 1'b1; bit_strobe = 1'b0; bit_in = 1'b0;
        bv_seen = 0; gv_seen = 0;
        model_reset();
        repeat (3) @(posedge clk);

        tbl[0]  = mk(64'h00000FC, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(64'h0000198, 1, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(64'h0000168, 1, 1, 2, 0, 0, 0, 0);
        tbl[3]  = mk(64'h00001B4, 1, 1, 4, 0, 0, 0, 0);
        tbl[4]  = mk(64'h0000545, 1, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(64'h0000198, 1, 1, 1, 0, 0, 0, 0);
        tbl[6]  = mk(64'h0000168, 1, 1, 2, 0, 0, 0, 0);
        tbl[7]  = mk(64'h00001B4, 1, 1, 4, 0, 1, 64'h0001_0000_0000_0000, 0);
        tbl[8]  = mk(64'h00000FC, 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(64'h0000198, 1, 1, 1, 0, 0, 0, 0);
        tbl[10] = mk(64'h0000350, 1, 1, 3, 0, 0, 0, 0);
        tbl[11] = mk(64'h00001B4, 1, 1, 4, 0, 1, 64'h0, 1);
        tbl[12] = mk(64'h00000FC, 1, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(64'h0000198, 1, 1, 1, 0, 0, 0, 0);
        tbl[14] = mk(64'h0000168, 1, 1, 2, 0, 0, 0, 0);
        tbl[15] = mk(64'h00001B4, 1, 1, 4, 0, 1, 64'h0, 0);

        // directed table after a 7-bit random lead-in
        do_reset();
        do r7 = int'($urandom_range(127)); while (!prefix_clean(r7));
        for (int i = 6; i >= 0; i--) send_bit(1'((r7 >> i) & 1));
        for (int i = 0; i < 16; i++) begin
            send_block(tbl[i].win);
            chk($sformatf("tbl%0d.synced", i), 64'(cap_sync), 64'(tbl[i].sync));
            chk($sformatf("tbl%0d.bvalid", i), 64'(cap_bv), 64'(tbl[i].bv));
            chk($sformatf("tbl%0d.gvalid", i), 64'(cap_gv), 64'(tbl[i].gv));
            if (tbl[i].bv) begin
                chk($sformatf("tbl%0d.bid", i), 64'(block_id), 64'(tbl[i].id));
                chk($sformatf("tbl%0d.bdata", i), 64'(block_data), 64'(tbl[i].data));
            end
            if (tbl[i].gv) begin
                chk($sformatf("tbl%0d.gdata", i), group_data, tbl[i].gdata);
                chk($sformatf("tbl%0d.gcprime", i), 64'(group_c_prime), 64'(tbl[i].cp));
            end
        end

        // four corrupted blocks then a good one keeps sync
        for (int i = 0; i < 4; i++) begin
            send_block(encode(0, pos_ofs[i]) ^ (64'h1 << $urandom_range(9)));
            chk($sformatf("loss4_%0d.synced", i), 64'(cap_sync), 64'h1);
        end
        send_block(encode(0, O_A));
        chk("recover.synced", 64'(cap_sync), 64'h1);
        chk("recover.bvalid", 64'(cap_bv), 64'h1);
        // five consecutive corrupted blocks drop sync on the fifth
        for (int i = 0; i < 5; i++) begin
            send_block(encode(0, pos_ofs[(i + 1) % 4]) ^ (64'h1 << $urandom_range(9)));
            chk($sformatf("loss5_%0d.synced", i), 64'(cap_sync), (i == 4) ? 64'h0 : 64'h1);
            chk($sformatf("loss5_%0d.bvalid", i), 64'(cap_bv), 64'h0);
        end

        // reset in the middle of block D discards the group
        do_reset();
        for (int i = 0; i < 7; i++) send_block(encode(0, pos_ofs[i % 4]));
        chk("pre_rst.synced", 64'(cap_sync), 64'h1);
        w = encode(0, O_D);
        for (int i = 25; i >= 13; i--) send_bit(w[i]);
        do_reset();
        chk("mid_rst.synced", 64'(synced), 64'h0);
        gv_seen = 0;
        for (int i = 12; i >= 0; i--) send_bit(w[i]);
        chk("mid_rst.no_group", 64'(gv_seen), 64'h0);

        // A followed by C must fail confirmation
        do_reset();
        bv_seen = 0;
        send_block(encode(0, O_A));
        send_block(encode(0, O_C));
        chk("order.no_bvalid", 64'(bv_seen), 64'h0);
        chk("order.synced", 64'(cap_sync), 64'h0);

        // random groups with occasional corruption and bit slips
        do_reset();
        for (int g = 0; g < 24; g++) begin
            if ($urandom_range(7) == 0) begin
                repeat ($urandom_range(1, 3)) send_bit(1'($urandom_range(1)));
            end
            for (int p = 0; p < 4; p++) begin
                int ofs;
                ofs = pos_ofs[p];
                if (p == 2 && $urandom_range(1) == 1) ofs = O_CP;
                w = encode(int'($urandom_range(65535)), ofs);
                if ($urandom_range(9) == 0) w = w ^ (64'h1 << $urandom_range(25));
                send_block(w);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
